// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage: HALT encoding, FSM states, stat events.
package fetch_pkg;

  localparam logic [4:0]  HALT_OPC   = 5'h1F;
  localparam logic [31:0] HALT_INSTR = 32'hF800_0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic fetched;
    logic stall;
  } stat_evt_t;

endpackage

// File: rtl/fetch_stat.sv
// Saturating event counter pair for fetch statistics (fetched words, RUN-state stall cycles).
module fetch_stat
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  stat_evt_t   evt,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_stall
);

  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q, stall_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    fetched_d = fetched_q;
    stall_d   = stall_q;
    if (evt.fetched && (fetched_q != 32'hFFFF_FFFF)) fetched_d = fetched_q + 32'd1;
    if (evt.stall && (stall_q != 32'hFFFF_FFFF))     stall_d   = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_stall   = stall_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC, BRAM read control, stall/redirect/halt handling.
// Optional FETCH_STAT_EN adds saturating fetched/stall counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                   ADDR_W   = 22,
  parameter int                   MEM_AW   = 7,
  parameter int                   INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               hlt,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               mem_en,
  output logic [MEM_AW-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
`ifdef FETCH_STAT_EN
  output logic [31:0]        stat_fetched,
  output logic [31:0]        stat_stall,
`endif
  output logic               halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] fetch_pc;
  logic              mem_en_c;
  logic              kill;
  logic              is_halt_op;

  assign kill       = (state_q == RUN) && br_taken;
  assign is_halt_op = (mem_rdata[INSTR_W-1 -: 5] == HALT_OPC);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    vld_d       = vld_q;
    mem_en_c    = 1'b0;
    fetch_pc    = pc_q;
    instr_valid = vld_q && (state_q == RUN) && !kill;
    case (state_q)
      BOOT: begin
        mem_en_c = 1'b1;
        fetch_pc = RESET_PC;
        pc_d     = RESET_PC + 1'b1;
        out_pc_d = RESET_PC;
        vld_d    = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        if (br_taken) begin
          mem_en_c = 1'b1;
          fetch_pc = br_target;
          pc_d     = br_target + 1'b1;
          out_pc_d = br_target;
          vld_d    = 1'b1;
        end else if (!stall) begin
          mem_en_c = 1'b1;
          pc_d     = pc_q + 1'b1;
          out_pc_d = pc_q;
          vld_d    = 1'b1;
        end
        // A HALT only retires when decode actually accepts it on the correct path.
        if (instr_valid && !stall && is_halt_op) state_d = HALTED;
      end
      default: ;
    endcase
    if (hlt) state_d = HALTED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      out_pc_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      out_pc_q <= out_pc_d;
      vld_q    <= vld_d;
    end
  end

  // BOOT is the reset state but must not read the BRAM while reset is held.
  assign mem_en   = mem_en_c && rst_n;
  assign mem_addr = fetch_pc[MEM_AW-1:0];
  assign halted   = (state_q == HALTED);
  assign instr    = halted ? INSTR_W'(HALT_INSTR) : mem_rdata;
  assign instr_pc = out_pc_q;

`ifdef FETCH_STAT_EN
  stat_evt_t evt;
  assign evt.fetched = instr_valid && !stall;
  assign evt.stall   = (state_q == RUN) && stall;

  fetch_stat u_stat (
    .clk          (clk),
    .rst_n        (rst_n),
    .evt          (evt),
    .stat_fetched (stat_fetched),
    .stat_stall   (stat_stall)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: vector table for the main flow, hand sequences for reset/hlt/stats.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int ADDR_W = 22;
  localparam int MEM_AW = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              stall = 1'b0, hlt = 1'b0, br_taken = 1'b0;
  logic [ADDR_W-1:0] br_target = '0;
  logic              mem_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata = '0;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid, halted;
`ifdef FETCH_STAT_EN
  logic [31:0]       stat_fetched, stat_stall;
`endif

  logic [31:0] mem [128];
  int checks = 0, failures = 0;

  fetch_ctrl #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .INSTR_W(32), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .hlt(hlt), .br_taken(br_taken),
    .br_target(br_target), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
`ifdef FETCH_STAT_EN
    .stat_fetched(stat_fetched), .stat_stall(stat_stall),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic              st, hl, br;
    logic [ADDR_W-1:0] tgt;
    logic              en;
    logic [MEM_AW-1:0] addr;
    logic [31:0]       ins;
    logic [ADDR_W-1:0] ipc;
    logic              vld, hal;
  } vec_t;

  function automatic vec_t mk(logic st, logic hl, logic br, logic [ADDR_W-1:0] tgt, logic en,
                              logic [MEM_AW-1:0] addr, logic [31:0] ins, logic [ADDR_W-1:0] ipc,
                              logic vld, logic hal);
    vec_t v;
    v.st = st; v.hl = hl; v.br = br; v.tgt = tgt; v.en = en; v.addr = addr;
    v.ins = ins; v.ipc = ipc; v.vld = vld; v.hal = hal;
    return v;
  endfunction

  function automatic logic [31:0] mw(int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  vec_t tv[$];
  localparam logic [31:0] H = 32'hF800_0000;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = mw(i);
    mem[5] = H;

    //                st hl br tgt        en addr   ins       ipc        vld hal
    tv.push_back(mk(0, 0, 0, 0,         1, 7'h00, 0,        0,         0, 0)); // BOOT
    tv.push_back(mk(0, 0, 0, 0,         1, 7'h01, mw(0),    0,         1, 0));
    tv.push_back(mk(1, 0, 0, 0,         0, 7'h02, mw(1),    1,         1, 0));
    tv.push_back(mk(1, 0, 0, 0,         0, 7'h02, mw(1),    1,         1, 0));
    tv.push_back(mk(1, 0, 0, 0,         0, 7'h02, mw(1),    1,         1, 0));
    tv.push_back(mk(0, 0, 0, 0,         1, 7'h02, mw(1),    1,         1, 0));
    tv.push_back(mk(0, 0, 1, 22'h40,    1, 7'h40, mw(2),    2,         0, 0)); // redirect kill
    tv.push_back(mk(0, 0, 0, 0,         1, 7'h41, mw('h40), 22'h40,    1, 0));
    tv.push_back(mk(0, 0, 1, 22'h3FFFFF,1, 7'h7F, mw('h41), 22'h41,    0, 0));
    tv.push_back(mk(0, 0, 0, 0,         1, 7'h00, mw('h7F), 22'h3FFFFF,1, 0)); // wrap
    tv.push_back(mk(0, 0, 1, 22'h4,     1, 7'h04, mw(0),    0,         0, 0));
    tv.push_back(mk(0, 0, 0, 0,         1, 7'h05, mw(4),    4,         1, 0));
    tv.push_back(mk(0, 0, 1, 22'h4,     1, 7'h04, H,        5,         0, 0)); // HALT on wrong path
    tv.push_back(mk(0, 0, 0, 0,         1, 7'h05, mw(4),    4,         1, 0));
    tv.push_back(mk(1, 0, 0, 0,         0, 7'h06, H,        5,         1, 0)); // stalled HALT
    tv.push_back(mk(0, 0, 0, 0,         1, 7'h06, H,        5,         1, 0)); // HALT accepted
    tv.push_back(mk(0, 0, 0, 0,         0, 7'h00, H,        0,         0, 1));
    tv.push_back(mk(0, 0, 1, 22'h40,    0, 7'h00, H,        0,         0, 1));
    tv.push_back(mk(0, 1, 0, 0,         0, 7'h00, H,        0,         0, 1));

    // reset state while held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", mem_en, 0);
    chk("rst_vld", instr_valid, 0);
    chk("rst_ipc", instr_pc, 0);
    chk("rst_halted", halted, 0);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      stall = tv[i].st; hlt = tv[i].hl; br_taken = tv[i].br; br_target = tv[i].tgt;
      @(negedge clk);
      chk($sformatf("v%0d_en", i), mem_en, tv[i].en);
      chk($sformatf("v%0d_vld", i), instr_valid, tv[i].vld);
      chk($sformatf("v%0d_halted", i), halted, tv[i].hal);
      if (tv[i].en) chk($sformatf("v%0d_addr", i), mem_addr, tv[i].addr);
      if (tv[i].vld || tv[i].hal) chk($sformatf("v%0d_instr", i), instr, tv[i].ins);
      if (tv[i].vld) chk($sformatf("v%0d_ipc", i), instr_pc, tv[i].ipc);
      next_cycle();
    end
    stall = 0; hlt = 0; br_taken = 0; br_target = '0;

    // mid-run async reset from HALTED, then re-boot
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_halted", halted, 0);
    chk("mid_rst_en", mem_en, 0);
    chk("mid_rst_vld", instr_valid, 0);
    chk("mid_rst_ipc", instr_pc, 0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("boot_en", mem_en, 1);
    chk("boot_addr", mem_addr, 0);
    chk("boot_vld", instr_valid, 0);
    next_cycle();
    @(negedge clk);
    chk("boot1_instr", instr, mw(0));
    chk("boot1_ipc", instr_pc, 0);
    chk("boot1_vld", instr_valid, 1);
    next_cycle();

    // external hlt overrides a same-cycle redirect
    hlt = 1; br_taken = 1; br_target = 22'h40;
    @(negedge clk);
    chk("hlt_cyc_addr", mem_addr, 7'h40);
    chk("hlt_cyc_vld", instr_valid, 0);
    next_cycle();
    hlt = 0; br_taken = 0;
    @(negedge clk);
    chk("hlt_halted", halted, 1);
    chk("hlt_en", mem_en, 0);
    chk("hlt_instr", instr, H);
    next_cycle();
    @(negedge clk);
    chk("hlt_sticky", halted, 1);

`ifdef FETCH_STAT_EN
    mem[5] = mw(5);
    rst_n = 1'b0;
    #1;
    chk("stat_rst_f", stat_fetched, 0);
    chk("stat_rst_s", stat_stall, 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();                            // BOOT
    repeat (10) next_cycle();                // 10 accepted fetches
    stall = 1;
    repeat (3) next_cycle();
    stall = 0;
    @(negedge clk);
    chk("stat_fetched", stat_fetched, 10);
    chk("stat_stall", stat_stall, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
